// File: rtl/music_box_state_sequencer_pkg.sv
// music_box_pkg: shared types and defaults for the music box state sequencer.
//   music_state_e : 5-bit state codes broadcast on currentState
//   seq_state_e   : sequencer FSM states (IDLE, ACTIVE, DRAIN)
//   DEFAULT_*     : default parameter values for the sequencer
package music_box_pkg;

    typedef enum logic [4:0] {
        STATE_DO_NOTHING     = 5'd0,
        STATE_PLAY_SONG0     = 5'd1,
        STATE_PLAY_SONG1     = 5'd2,
        STATE_RECORD         = 5'd3,
        STATE_PLAY_RECORDING = 5'd4
    } music_state_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } seq_state_e;

    localparam logic [4:0]  DEFAULT_MAX_STATE       = 5'd7;
    localparam int unsigned DEFAULT_GUARD_CYCLES    = 100000;
    localparam logic [31:0] DEFAULT_WATCHDOG_CYCLES = 32'd500000000;

endpackage

// File: rtl/music_box_state_sequencer_if.sv
// music_box_state_sequencer_if: mode request channel from the UI decoder.
//   request_valid : UI requests a mode
//   request_state : requested 5-bit state code
//   request_ready : sequencer can accept (IDLE only)
//   cancel        : level, aborts the active mode
// Modports: master = UI side, slave = sequencer side.
interface music_box_state_sequencer_if;

    logic       request_valid;
    logic [4:0] request_state;
    logic       request_ready;
    logic       cancel;

    modport master (
        output request_valid,
        output request_state,
        output cancel,
        input  request_ready
    );

    modport slave (
        input  request_valid,
        input  request_state,
        input  cancel,
        output request_ready
    );

endinterface

// File: rtl/music_box_state_sequencer_sync_edge.sv
// music_box_sync_edge: 2-flop synchroniser plus rising-edge detector.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_async        : asynchronous input level
//   i_clr          : clears the edge history so a level already high
//                    on the next cycle is reported as a rising edge
//   o_level        : synchronised level
//   o_rise         : rising edge of o_level
module music_box_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    input  logic i_clr,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= i_clr ? 1'b0 : r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/music_box_state_sequencer.sv
// music_box_state_sequencer: drives the currentState bus watched by all
// MusicBoxState_* modules, accepts one mode request at a time and returns
// to DoNothing on completion, cancel or (optionally) watchdog timeout.
//   clock_50Mhz, reset_n : clock, asynchronous active-low reset
//   req (slave)          : request_valid/request_state/request_ready/cancel
//   stateComplete        : OR of state modules' flags, 1 kHz domain
//   currentState         : registered state code broadcast
//   busy                 : high in ACTIVE or DRAIN
//   completed_pulse      : one cycle, mode ended via stateComplete
//   rejected_pulse       : one cycle, handshake carried an illegal code
//   debugString          : {fsm[1:0], 6'b0, lastState, 3'b0, guard[15:0]}
// Optional macro MUSICBOX_STATE_WATCHDOG_EN: ACTIVE timeout acting as
// cancel; debugString[31] then becomes a sticky watchdog-fired flag.
module music_box_state_sequencer
    import music_box_pkg::*;
#(
    parameter logic [4:0]  MAX_STATE       = DEFAULT_MAX_STATE,
    parameter int unsigned GUARD_CYCLES    = DEFAULT_GUARD_CYCLES,
    parameter logic [31:0] WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES
) (
    input  logic                          clock_50Mhz,
    input  logic                          reset_n,
    music_box_state_sequencer_if.slave    req,
    input  logic                          stateComplete,
    output logic [4:0]                    currentState,
    output logic                          busy,
    output logic                          completed_pulse,
    output logic                          rejected_pulse,
    output logic [31:0]                   debugString
);

    localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);

    seq_state_e  r_state, w_state_nxt;
    logic [4:0]  r_cur, w_cur_nxt;
    logic [4:0]  r_last, w_last_nxt;
    logic [31:0] r_guard, w_guard_nxt;
    logic        r_done, w_done_nxt;
    logic        r_rej, w_rej_nxt;

    logic w_accept;
    logic w_legal;
    logic w_accept_ok;
    logic w_sc_level;
    logic w_sc_rise;
    logic w_wd_fire;
    logic w_dbg_top;

    music_box_sync_edge u_sc_sync (
        .i_clk   (clock_50Mhz),
        .i_rst_n (reset_n),
        .i_async (stateComplete),
        .i_clr   (w_accept_ok),
        .o_level (w_sc_level),
        .o_rise  (w_sc_rise)
    );

    assign req.request_ready = (r_state == IDLE) && reset_n;
    assign w_accept    = req.request_valid && req.request_ready;
    assign w_legal     = (req.request_state != 5'd0) && (req.request_state <= MAX_STATE);
    assign w_accept_ok = w_accept && w_legal;

`ifdef MUSICBOX_STATE_WATCHDOG_EN
    logic [31:0] r_wd;
    logic        r_wd_sticky;

    assign w_wd_fire = (r_state == ACTIVE) && (r_wd == WATCHDOG_CYCLES - 32'd1);

    // Counter is zero outside ACTIVE, so it starts from 0 on every entry.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_wd        <= '0;
            r_wd_sticky <= 1'b0;
        end else begin
            r_wd <= (r_state == ACTIVE) ? r_wd + 32'd1 : '0;
            if (w_accept_ok)
                r_wd_sticky <= 1'b0;
            else if (w_wd_fire && !w_sc_rise)
                r_wd_sticky <= 1'b1;
        end
    end

    assign w_dbg_top = r_wd_sticky;
`else
    logic w_unused_wd;
    assign w_unused_wd = &WATCHDOG_CYCLES;
    assign w_wd_fire   = 1'b0;
    assign w_dbg_top   = r_state[1];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_last_nxt  = r_last;
        w_guard_nxt = r_guard;
        w_done_nxt  = 1'b0;
        w_rej_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_guard_nxt = '0;
                if (w_accept) begin
                    if (w_legal) begin
                        w_state_nxt = ACTIVE;
                        w_cur_nxt   = req.request_state;
                        w_last_nxt  = req.request_state;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // Completion takes priority over cancel and watchdog.
                if (w_sc_rise) begin
                    w_state_nxt = DRAIN;
                    w_cur_nxt   = STATE_DO_NOTHING;
                    w_guard_nxt = '0;
                    w_done_nxt  = 1'b1;
                end else if (req.cancel || w_wd_fire) begin
                    w_state_nxt = DRAIN;
                    w_cur_nxt   = STATE_DO_NOTHING;
                    w_guard_nxt = '0;
                end
            end
            DRAIN: begin
                // Counter saturates at the last guard cycle while the
                // synchronised completion flag is still high.
                if (r_guard == GUARD_LAST) begin
                    if (!w_sc_level) begin
                        w_state_nxt = IDLE;
                        w_guard_nxt = '0;
                    end
                end else begin
                    w_guard_nxt = r_guard + 32'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cur_nxt   = STATE_DO_NOTHING;
                w_guard_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cur   <= STATE_DO_NOTHING;
            r_last  <= '0;
            r_guard <= '0;
            r_done  <= 1'b0;
            r_rej   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_last  <= w_last_nxt;
            r_guard <= w_guard_nxt;
            r_done  <= w_done_nxt;
            r_rej   <= w_rej_nxt;
        end
    end

    assign currentState    = r_cur;
    assign busy            = (r_state != IDLE);
    assign completed_pulse = r_done;
    assign rejected_pulse  = r_rej;
    assign debugString     = {w_dbg_top, r_state[0], 6'b0, r_last, 3'b0, r_guard[15:0]};

endmodule

// File: tb/tb_music_box_state_sequencer.sv
module tb_music_box_state_sequencer;
    import music_box_pkg::*;

    localparam int unsigned G = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sc = 1'b0;
    logic [4:0]  cur;
    logic        busy;
    logic        done;
    logic        rej;
    logic [31:0] dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int rej_cnt  = 0;
    int n;

    music_box_state_sequencer_if ifc ();

    music_box_state_sequencer #(
        .MAX_STATE       (5'd7),
        .GUARD_CYCLES    (G),
        .WATCHDOG_CYCLES (32'd1000)
    ) dut (
        .clock_50Mhz     (clk),
        .reset_n         (rst_n),
        .req             (ifc.slave),
        .stateComplete   (sc),
        .currentState    (cur),
        .busy            (busy),
        .completed_pulse (done),
        .rejected_pulse  (rej),
        .debugString     (dbg)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        done_cnt += int'(done);
        rej_cnt  += int'(rej);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [4:0] code);
        ifc.request_valid = 1'b1;
        ifc.request_state = code;
        tick();
        ifc.request_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cnt);
        cnt = 0;
        while (busy && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_cur_zero(input int limit, output int cnt);
        cnt = 0;
        while (cur != 5'd0 && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        ifc.request_valid = 1'b0;
        ifc.request_state = 5'd0;
        ifc.cancel        = 1'b0;

        // Reset state
        #1;
        chk("rst_cur",   32'(cur), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(ifc.request_ready), 32'd0);
        chk("rst_dbg",   dbg, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ifc.request_ready), 32'd1);
        tick();

        // Accept state 2, complete via stateComplete
        done_cnt = 0;
        do_req(5'd2);
        chk("acc2_cur",   32'(cur), 32'd2);
        chk("acc2_busy",  32'(busy), 32'd1);
        chk("acc2_ready", 32'(ifc.request_ready), 32'd0);
        chk("acc2_dbg",   dbg, 32'h4010_0000);
        sc = 1'b1;
        wait_cur_zero(8, n);
        chk("sc_latency", 32'(n), 32'd3);
        chk("sc_done_now", 32'(done), 32'd1);
        repeat (9) tick();
        sc = 1'b0;
        wait_idle(200, n);
        chk("drain_len", 32'(n + 9), 32'(G));
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("idle_ready", 32'(ifc.request_ready), 32'd1);

        // Illegal codes and boundary
        rej_cnt = 0;
        do_req(5'd0);
        chk("rej0_pulse", 32'(rej), 32'd1);
        chk("rej0_cur",   32'(cur), 32'd0);
        chk("rej0_busy",  32'(busy), 32'd0);
        tick();
        chk("rej0_end", 32'(rej), 32'd0);
        do_req(5'd9);
        chk("rej9_pulse", 32'(rej), 32'd1);
        chk("rej9_ready", 32'(ifc.request_ready), 32'd1);
        tick();
        do_req(5'd8);
        chk("rej8_pulse", 32'(rej), 32'd1);
        tick();
        chk("rej_total", 32'(rej_cnt), 32'd3);
        ifc.cancel = 1'b1;
        tick();
        chk("idle_cancel_busy", 32'(busy), 32'd0);
        ifc.cancel = 1'b0;
        do_req(5'd7);
        chk("acc7_cur", 32'(cur), 32'd7);
        chk("acc7_rej", 32'(rej), 32'd0);
        ifc.cancel = 1'b1;
        tick();
        ifc.cancel = 1'b0;
        chk("cancel7_cur", 32'(cur), 32'd0);
        wait_idle(200, n);

        // Cancel after 500 active cycles
        done_cnt = 0;
        do_req(5'd3);
        repeat (499) tick();
        chk("hold3_cur", 32'(cur), 32'd3);
        ifc.cancel = 1'b1;
        tick();
        ifc.cancel = 1'b0;
        chk("cancel3_cur",  32'(cur), 32'd0);
        chk("cancel3_busy", 32'(busy), 32'd1);
        wait_idle(200, n);
        chk("cancel3_drain", 32'(n), 32'(G));
        chk("cancel3_nodone", 32'(done_cnt), 32'd0);

        // stateComplete held high through DRAIN
        do_req(5'd1);
        sc = 1'b1;
        wait_cur_zero(8, n);
        chk("stuck_latency", 32'(n), 32'd3);
        repeat (40) tick();
        chk("stuck_busy", 32'(busy), 32'd1);
`ifdef MUSICBOX_STATE_WATCHDOG_EN
        chk("stuck_dbg", dbg, 32'h0008_0013);
`else
        chk("stuck_dbg", dbg, 32'h8008_0013);
`endif
        ifc.request_valid = 1'b1;
        ifc.request_state = 5'd2;
        #1;
        chk("drain_ready", 32'(ifc.request_ready), 32'd0);
        tick();
        ifc.request_valid = 1'b0;
        chk("drain_noacc", 32'(cur), 32'd0);
        sc = 1'b0;
        wait_idle(50, n);
        chk("stuck_exit", 32'(n), 32'd3);
        chk("stuck_idle_cur", 32'(cur), 32'd0);

        // Asynchronous reset mid-ACTIVE
        do_req(5'd4);
        repeat (5) tick();
        chk("acc4_cur", 32'(cur), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cur",  32'(cur), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dbg",  dbg, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst_ready", 32'(ifc.request_ready), 32'd1);
        tick();

`ifdef MUSICBOX_STATE_WATCHDOG_EN
        // Watchdog timeout
        done_cnt = 0;
        do_req(5'd1);
        wait_cur_zero(1100, n);
        chk("wd_latency", 32'(n), 32'd1000);
        chk("wd_sticky",  32'(dbg[31]), 32'd1);
        chk("wd_nodone",  32'(done_cnt), 32'd0);
        wait_idle(200, n);
        chk("wd_sticky_idle", 32'(dbg[31]), 32'd1);
        do_req(5'd2);
        chk("wd_clear", 32'(dbg[31]), 32'd0);
        ifc.cancel = 1'b1;
        tick();
        ifc.cancel = 1'b0;
        wait_idle(200, n);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
